// File: rtl/wallace_8x8_product.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wallace_8x8_product                                                  |
// | Unsigned 8x8 Wallace-tree multiplier, registered 16-bit product.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

// Three-row carry-save stage: one full-adder cell per column. Columns where
// a row is constant zero fold into half adders or pass-throughs at synthesis.
module wallace_csa16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] w,
   output logic [15:0] s,
   output logic [15:0] c
);
   logic [14:0] w_maj;

   assign s     = x ^ y ^ w;
   // The column-15 carry would have weight 2^16, which a product below 2^16 never reaches.
   assign w_maj = (x[14:0] & y[14:0]) | (x[14:0] & w[14:0]) | (y[14:0] & w[14:0]);
   assign c     = {w_maj, 1'b0};
endmodule

module wallace_8x8_product (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] z
);
   localparam int C_ROWS = 8;

   logic [15:0] w_pp [C_ROWS];
   logic [15:0] w_s1 [6];
   logic [15:0] w_s2 [4];
   logic [15:0] w_s3 [3];
   logic [15:0] w_s4 [2];
   logic [15:0] w_cy;
   logic [15:0] w_p;
   logic [15:0] r_z;

   generate
      for (genvar i = 0; i < C_ROWS; i++) begin : g_pp
         assign w_pp[i] = {8'h00, a & {8{b[i]}}} << i;
      end
   endgenerate

   // Stage 1: 8 -> 6 rows
   wallace_csa16 u_s1a (.x(w_pp[0]), .y(w_pp[1]), .w(w_pp[2]), .s(w_s1[0]), .c(w_s1[1]));
   wallace_csa16 u_s1b (.x(w_pp[3]), .y(w_pp[4]), .w(w_pp[5]), .s(w_s1[2]), .c(w_s1[3]));
   assign w_s1[4] = w_pp[6];
   assign w_s1[5] = w_pp[7];

   // Stage 2: 6 -> 4 rows
   wallace_csa16 u_s2a (.x(w_s1[0]), .y(w_s1[1]), .w(w_s1[2]), .s(w_s2[0]), .c(w_s2[1]));
   wallace_csa16 u_s2b (.x(w_s1[3]), .y(w_s1[4]), .w(w_s1[5]), .s(w_s2[2]), .c(w_s2[3]));

   // Stage 3: 4 -> 3 rows
   wallace_csa16 u_s3a (.x(w_s2[0]), .y(w_s2[1]), .w(w_s2[2]), .s(w_s3[0]), .c(w_s3[1]));
   assign w_s3[2] = w_s2[3];

   // Stage 4: 3 -> 2 rows
   wallace_csa16 u_s4a (.x(w_s3[0]), .y(w_s3[1]), .w(w_s3[2]), .s(w_s4[0]), .c(w_s4[1]));

   // Final ripple-carry adder; carry out of bit 15 is never formed.
   assign w_cy[0] = 1'b0;
   generate
      for (genvar i = 0; i < 16; i++) begin : g_rca
         assign w_p[i] = w_s4[0][i] ^ w_s4[1][i] ^ w_cy[i];
         if (i < 15) begin : g_carry
            assign w_cy[i+1] = (w_s4[0][i] & w_s4[1][i]) |
                               (w_s4[0][i] & w_cy[i])    |
                               (w_s4[1][i] & w_cy[i]);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) r_z <= 16'h0000;
      else     r_z <= w_p;
   end

   assign z = r_z;
endmodule
`default_nettype wire

// File: tb/tb_wallace_8x8_product.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wallace_8x8_product                                               |
// | Self-checking bench: directed, streaming, reset, random, exhaustive. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wallace_8x8_product;
   logic        clk;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] z;

   int n_cmp = 0;
   int n_err = 0;

   wallace_8x8_product dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .z   (z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: z after the edge is the plain arithmetic product of the
   // inputs held across that edge, or zero when reset is sampled.
   function automatic logic [15:0] ref_z(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic rr);
      return rr ? 16'h0000 : 16'(ra) * 16'(rb);
   endfunction

   task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic nr,
                       input string tag);
      @(negedge clk);
      a   = na;
      b   = nb;
      rst = nr;
      @(posedge clk);
      #1;
      check_eq(tag, z, ref_z(na, nb, nr));
   endtask

   // Same as step but the expected value is a literal from the test plan.
   task automatic step_lit(input logic [7:0] na, input logic [7:0] nb, input logic nr,
                           input logic [15:0] lit, input string tag);
      @(negedge clk);
      a   = na;
      b   = nb;
      rst = nr;
      @(posedge clk);
      #1;
      check_eq(tag, z, lit);
   endtask

   logic [7:0] spot [5];

   initial begin
      rst = 1'b1;
      a   = 8'hff;
      b   = 8'hff;
      spot[0] = 8'h00; spot[1] = 8'h01; spot[2] = 8'h7f; spot[3] = 8'h80; spot[4] = 8'hff;

      step_lit(8'hff, 8'hff, 1'b1, 16'h0000, "reset0");
      step_lit(8'hff, 8'hff, 1'b1, 16'h0000, "reset1");
      step_lit(8'hff, 8'hff, 1'b0, 16'hfe01, "reset_release");

      step_lit(8'h00, 8'h01, 1'b0, 16'h0000, "dir00x01");
      step_lit(8'h01, 8'h01, 1'b0, 16'h0001, "dir01x01");
      step_lit(8'h01, 8'h02, 1'b0, 16'h0002, "dir01x02");
      step_lit(8'h01, 8'h03, 1'b0, 16'h0003, "dir01x03");
      step_lit(8'h01, 8'h04, 1'b0, 16'h0004, "dir01x04");
      step_lit(8'h02, 8'h01, 1'b0, 16'h0002, "dir02x01");
      step_lit(8'h03, 8'h02, 1'b0, 16'h0006, "dir03x02");
      step_lit(8'h04, 8'h03, 1'b0, 16'h000c, "dir04x03");
      step_lit(8'hff, 8'h04, 1'b0, 16'h03fc, "dirffx04");

      step_lit(8'hff, 8'hff, 1'b0, 16'hfe01, "stream0");
      step_lit(8'h80, 8'h80, 1'b0, 16'h4000, "stream1");
      step_lit(8'h0f, 8'hf0, 1'b0, 16'h0e10, "stream2");

      step_lit(8'hff, 8'hff, 1'b0, 16'hfe01, "mid_pre");
      step_lit(8'haa, 8'h55, 1'b1, 16'h0000, "mid_rst");
      step_lit(8'haa, 8'h55, 1'b0, 16'h3872, "mid_post");

      for (int i = 0; i < 5; i++) begin
         step_lit(spot[i], 8'h00, 1'b0, 16'h0000, "spot_ax0");
         step_lit(8'h00, spot[i], 1'b0, 16'h0000, "spot_0xa");
         step_lit(spot[i], 8'h01, 1'b0, {8'h00, spot[i]}, "spot_ax1");
      end

      for (int i = 0; i < 2000; i++) begin
         step(8'($urandom), 8'($urandom), 1'b0, "random");
      end

      for (int i = 0; i < 65536; i++) begin
         step(8'(i >> 8), 8'(i), 1'b0, "exhaustive");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
